// File: rtl/cbus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbus_arb_pkg
// Description : Types and defaults for the cbus arbiter: FSM state encoding,
//               port index type and the default number of upstream masters.
// Revision    : 1.0 - initial release
// ============================================================================
package cbus_arb_pkg;

    localparam int CBUS_ARB_NUM_PORTS = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index type sized for the default port count.
    typedef logic [$clog2(CBUS_ARB_NUM_PORTS)-1:0] port_idx_t;

endpackage
`default_nettype wire

// File: rtl/cbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbus_pkg
// Description : Shared cache-bus (cbus) request/response structures used by
//               the DCache/ICache creq/cresp ports, the arbiter and the
//               memory/AXI bridge.
//               cbus_req_t  : valid, is_write, addr, len (beats), size,
//                             data, strobe
//               cbus_resp_t : ready (beat accepted/returned), last, data
// Revision    : 1.0 - initial release
// ============================================================================
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [7:0]  len;      // burst length in beats
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage
`default_nettype wire

// File: rtl/cbus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Returns the index of the
//               first set bit of 'valid' at or after 'rr_ptr', searching
//               cyclically, plus a flag saying whether any bit is set.
// Ports       : valid     in  [N]          request vector
//               rr_ptr    in  [clog2(N)]   highest-priority index
//               grant     out [clog2(N)]   selected index ('0 if none)
//               any_valid out 1            at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [$clog2(N)-1:0] grant,
    output logic                 any_valid
);

    localparam int IDX_W = $clog2(N);

    int idx;

    // Walk offsets from farthest to nearest so the nearest valid port
    // (smallest cyclic distance from rr_ptr) is written last and wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (valid[idx[IDX_W-1:0]]) begin
                grant = idx[IDX_W-1:0];
            end
        end
    end

    assign any_valid = |valid;

endmodule
`default_nettype wire

// File: rtl/cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cbus_arbiter
// Description : Multiplexes NUM_PORTS cache-side cbus masters (port 0 =
//               ICache, port 1 = DCache) onto the single memory-side cbus.
//               Registered round-robin grant, locked for a whole transaction
//               and released on the beat carrying oresp.ready && oresp.last.
//               One IDLE bubble cycle separates consecutive transactions.
// Ports       : clk        in   clock, rising edge
//               resetn     in   asynchronous active-low reset
//               ireqs      in   cbus_req_t  [NUM_PORTS] master requests
//               iresps     out  cbus_resp_t [NUM_PORTS] master responses
//               oreq       out  cbus_req_t  request to memory side
//               oresp      in   cbus_resp_t response from memory side
//               grant_cnt  out  [NUM_PORTS][STAT_WIDTH] grants per port
//                               (only with CBUS_ARB_STATS_EN)
// Config      : `define CBUS_ARB_STATS_EN adds the grant_cnt port, the
//               STAT_WIDTH parameter and per-port wrapping grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_arbiter
    import cbus_pkg::*;
    import cbus_arb_pkg::*;
#(
    parameter int NUM_PORTS  = CBUS_ARB_NUM_PORTS
`ifdef CBUS_ARB_STATS_EN
   ,parameter int STAT_WIDTH = 32
`endif
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  ireqs  [NUM_PORTS],
    output cbus_resp_t iresps [NUM_PORTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
`ifdef CBUS_ARB_STATS_EN
   ,output logic [STAT_WIDTH-1:0] grant_cnt [NUM_PORTS]
`endif
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_t           state;
    arb_state_t           next_state;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     next_owner;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     next_rr_ptr;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_PORTS-1:0] req_valid;
    logic                 any_valid;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_valid
        assign req_valid[i] = ireqs[i].valid;
    end

    rr_picker #(
        .N (NUM_PORTS)
    ) u_picker (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_idx),
        .any_valid (any_valid)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= next_state;
            owner  <= next_owner;
            rr_ptr <= next_rr_ptr;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        next_owner  = owner;
        next_rr_ptr = rr_ptr;
        case (state)
            IDLE: begin
                // Memory-side ready/last are ignored here: nothing is owned.
                if (any_valid) begin
                    next_state = BUSY;
                    next_owner = pick_idx;
                end
            end
            BUSY: begin
                if (oresp.ready && oresp.last) begin
                    next_state  = IDLE;
                    next_rr_ptr = (owner == IDX_W'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath routing: the owner's request is forwarded live each beat,
    // so changes in its write data reach memory without extra latency.
    // ------------------------------------------------------------------
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            iresps[i] = '0;
        end
        if (state == BUSY) begin
            oreq          = ireqs[owner];
            iresps[owner] = oresp;
        end
    end

`ifdef CBUS_ARB_STATS_EN
    logic grant_fire;

    assign grant_fire = (state == IDLE) && any_valid;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stats
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                grant_cnt[i] <= '0;
            end else if (grant_fire && (pick_idx == IDX_W'(i))) begin
                grant_cnt[i] <= grant_cnt[i] + 1'b1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // The owning master must hold valid until its last beat completes.
    always @(posedge clk) begin
        if (resetn && (state == BUSY)) begin
            assert (ireqs[owner].valid)
                else $error("cbus_arbiter: owner %0d dropped valid mid-transaction", owner);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbus_arbiter
// Description : Self-checking bench for cbus_arbiter. Directed scenarios
//               (reset, single burst, contention, lock, mid-op reset, stats)
//               followed by randomized traffic, all checked every cycle
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  ireqs  [N];
    cbus_resp_t iresps [N];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
`ifdef CBUS_ARB_STATS_EN
    logic [31:0] grant_cnt [N];
`endif

    always #5 clk = ~clk;

    cbus_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
`ifdef CBUS_ARB_STATS_EN
       ,.grant_cnt (grant_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the bus (-1 = nobody), who owned it last,
    // beats completed in the current transaction, grants per port.
    int          m_owner;
    int          m_last;
    int          m_beats;
    int          m_done;
    logic [31:0] m_cnt [N];
    int          cyc;
    logic        prev_v;
    int          obs_q [$];
    int          obs_c [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_req(input string tag, input cbus_req_t got, input cbus_req_t exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cbus_req_t mk_req(input logic [31:0] addr, input int len, input bit wr);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.len      = 8'(len);
        r.size     = 3'd2;
        r.strobe   = wr ? 4'hf : 4'h0;
        r.data     = $urandom();
        return r;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_beats = 0;
        m_done  = -1;
        for (int p = 0; p < N; p++) m_cnt[p] = '0;
    endtask

    // Next owner = first requester cyclically after the previous owner.
    task automatic model_update();
        m_done = -1;
        if (!resetn) begin
            model_reset();
        end else if (m_owner < 0) begin
            bit found;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (m_last + k) % N;
                if (!found && ireqs[p].valid) begin
                    found    = 1'b1;
                    m_owner  = p;
                    m_beats  = 0;
                    m_cnt[p] = m_cnt[p] + 1;
                end
            end
        end else if (oresp.ready) begin
            if (oresp.last) begin
                m_done  = m_owner;
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_beats++;
            end
        end
    endtask

    // Bench memory: raises last on the final beat of the owner's burst.
    task automatic drive_resp(input bit rdy);
        oresp.ready = rdy;
        oresp.data  = $urandom();
        oresp.last  = 1'b0;
        if (rdy && m_owner >= 0) begin
            oresp.last = (m_beats == int'(ireqs[m_owner].len) - 1);
        end
    endtask

    task automatic check_now();
        cbus_req_t  er;
        cbus_resp_t ers;
        #2;
        er = (m_owner >= 0) ? ireqs[m_owner] : '0;
        chk_req("oreq", oreq, er);
        for (int p = 0; p < N; p++) begin
            ers = (m_owner == p) ? oresp : '0;
            chk($sformatf("iresps[%0d]", p), 64'(iresps[p]), 64'(ers));
        end
        if (oreq.valid && !prev_v) begin
            int who;
            who = -1;
            for (int p = 0; p < N; p++) if (ireqs[p] === oreq) who = p;
            obs_q.push_back(who);
            obs_c.push_back(cyc);
        end
        prev_v = oreq.valid;
    endtask

    task automatic clock();
        @(posedge clk);
        #1;
        model_update();
        cyc++;
        if (!resetn) prev_v = 1'b0;
        if (m_done >= 0) ireqs[m_done] = '0;
    endtask

    task automatic step();
        check_now();
        clock();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive_resp(1'b0);
        check_now();
        clock();
        resetn = 1'b1;
    endtask

    initial begin
        int guard;
        cyc    = 0;
        prev_v = 1'b0;
        resetn = 1'b0;
        model_reset();

        // ---------------- 1: reset with port0 requesting ----------------
        ireqs[0] = mk_req(32'h1000_0000, 1, 1'b0);
        ireqs[1] = '0;
        drive_resp(1'b0);
        repeat (3) begin
            check_now();
            chk("t1_rst_valid", 64'(oreq.valid), 64'd0);
            chk("t1_rst_iresp0", 64'(iresps[0]), 64'd0);
            chk("t1_rst_iresp1", 64'(iresps[1]), 64'd0);
            clock();
        end
        resetn = 1'b1;
        drive_resp(1'b0);
        check_now();
        chk("t1_first_idle", 64'(oreq.valid), 64'd0);
        clock();
        drive_resp(1'b1);
        check_now();
        chk("t1_valid", 64'(oreq.valid), 64'd1);
        chk("t1_addr", 64'(oreq.addr), 64'h1000_0000);
        clock();

        // ---------------- 2: single 4-beat burst on port1 ----------------
        ireqs[1] = mk_req(32'h8000_0040, 4, 1'b0);
        drive_resp(1'b0);
        step();
        for (int b = 0; b < 4; b++) begin
            drive_resp(1'b1);
            check_now();
            chk("t2_ready", 64'(iresps[1].ready), 64'd1);
            chk("t2_last", 64'(iresps[1].last), (b == 3) ? 64'd1 : 64'd0);
            chk("t2_addr", 64'(oreq.addr), 64'h8000_0040);
            clock();
        end
        drive_resp(1'b0);
        check_now();
        chk("t2_idle", 64'(oreq.valid), 64'd0);
        clock();

        // ---------------- 3: contention from reset ----------------
        ireqs[0] = mk_req(32'h0000_0100, 1, 1'b0);
        ireqs[1] = mk_req(32'h0000_0200, 1, 1'b1);
        do_reset();
        obs_q.delete();
        obs_c.delete();
        guard = 0;
        while (obs_q.size() < 4 && guard < 30) begin
            drive_resp(1'b1);
            check_now();
            if (obs_q.size() < 4) begin
                clock();
                if (m_done == 0) ireqs[0] = mk_req(32'h0000_0100, 1, 1'b0);
                if (m_done == 1) ireqs[1] = mk_req(32'h0000_0200, 1, 1'b1);
            end
            guard++;
        end
        chk("t3_count", 64'(obs_q.size()), 64'd4);
        for (int k = 0; k < obs_q.size() && k < 4; k++) begin
            chk($sformatf("t3_order%0d", k), 64'(obs_q[k]), 64'(k % 2));
            if (k > 0) chk($sformatf("t3_gap%0d", k), 64'(obs_c[k] - obs_c[k-1]), 64'd2);
        end
        // ---------------- 6: stats after contention ----------------
`ifdef CBUS_ARB_STATS_EN
        chk("t6_cnt0", 64'(grant_cnt[0]), 64'd2);
        chk("t6_cnt1", 64'(grant_cnt[1]), 64'd2);
`endif
        ireqs[0] = '0;
        clock();

        // ---------------- 4: grant lock during 8-beat burst ----------------
        ireqs[0] = '0;
        ireqs[1] = '0;
        do_reset();
        ireqs[0] = mk_req(32'h0000_1000, 8, 1'b1);
        drive_resp(1'b0);
        step();
        for (int b = 0; b < 8; b++) begin
            drive_resp(1'b1);
            if (b == 2) ireqs[1] = mk_req(32'h0000_2000, 1, 1'b0);
            check_now();
            chk("t4_lock", 64'(oreq.addr), 64'h0000_1000);
            clock();
        end
        drive_resp(1'b0);
        check_now();
        chk("t4_bubble", 64'(oreq.valid), 64'd0);
        clock();
        drive_resp(1'b1);
        check_now();
        chk("t4_next_valid", 64'(oreq.valid), 64'd1);
        chk("t4_next_addr", 64'(oreq.addr), 64'h0000_2000);
        clock();

        // ---------------- 5: reset in the middle of a port1 burst ----------------
        ireqs[0] = mk_req(32'h0000_0500, 1, 1'b0);
        drive_resp(1'b0);
        step();
        drive_resp(1'b1);
        step();
        ireqs[1] = mk_req(32'h8000_0040, 6, 1'b0);
        drive_resp(1'b0);
        step();
        drive_resp(1'b1);
        step();
        drive_resp(1'b1);
        #1;
        resetn = 1'b0;
        #1;
        chk("t5_abort", 64'(oreq.valid), 64'd0);
        model_reset();
        prev_v   = 1'b0;
        ireqs[1] = '0;
        drive_resp(1'b0);
        step();
        ireqs[0] = mk_req(32'h0000_3000, 1, 1'b0);
        ireqs[1] = mk_req(32'h0000_4000, 1, 1'b0);
        resetn   = 1'b1;
        step();
        drive_resp(1'b1);
        check_now();
        chk("t5_ptr_zero", 64'(oreq.addr), 64'h0000_3000);
        clock();
        repeat (4) begin
            drive_resp(1'b1);
            step();
        end
        chk("t5_drained", 64'(ireqs[0].valid | ireqs[1].valid), 64'd0);

        // ---------------- randomized traffic ----------------
        ireqs[0] = '0;
        ireqs[1] = '0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int p = 0; p < N; p++) begin
                if (!ireqs[p].valid && $urandom_range(0, 3) == 0) begin
                    logic [31:0] a;
                    a    = $urandom();
                    a[0] = p[0];
                    ireqs[p] = mk_req(a, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
                end else if (ireqs[p].valid) begin
                    ireqs[p].data = $urandom();
                end
            end
            if (m_owner >= 0) begin
                drive_resp($urandom_range(0, 9) < 7);
            end else begin
                oresp.ready = 1'($urandom_range(0, 1));
                oresp.last  = 1'($urandom_range(0, 1));
                oresp.data  = $urandom();
            end
            step();
        end
`ifdef CBUS_ARB_STATS_EN
        for (int p = 0; p < N; p++) begin
            chk($sformatf("rand_cnt%0d", p), 64'(grant_cnt[p]), 64'(m_cnt[p]));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
